// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-rate divider, x/y scan counters, and registered
// video_on/hsync/vsync plus line/frame start markers aligned with the counters.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // 11-bit decode bounds so a 1024-wide region end still fits
  localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
  localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be 1..16");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must be <= 1024");
  end
  if (H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_zero
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must be non-zero");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             p_tick_q, p_tick_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             x_wrap, y_wrap;
  logic             in_hs, in_vs;

  // Pixel enable: one clk high after div reaches its last count
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    p_tick_d = (div_q == DIV_LAST);
  end

  always_comb begin
    x_wrap = p_tick_q && (x_q == H_LAST);
    y_wrap = x_wrap && (y_q == V_LAST);
    x_d    = x_q;
    y_d    = y_q;
    if (p_tick_q) x_d = x_wrap ? 10'd0 : x_q + 10'd1;
    if (x_wrap)   y_d = y_wrap ? 10'd0 : y_q + 10'd1;
  end

  // Decode from next-state counters so the registered flags line up with x/y
  always_comb begin
    in_hs         = ({1'b0, x_d} >= HS_START) && ({1'b0, x_d} < HS_END);
    in_vs         = ({1'b0, y_d} >= VS_START) && ({1'b0, y_d} < VS_END);
    video_on_d    = ({1'b0, x_d} < H_VIS) && ({1'b0, y_d} < V_VIS);
    hsync_d       = in_hs ? SYNC_POL : ~SYNC_POL;
    vsync_d       = in_vs ? SYNC_POL : ~SYNC_POL;
    line_start_d  = x_wrap;
    frame_start_d = y_wrap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      p_tick_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      p_tick_q      <= p_tick_d;
      x_q           <= x_d;
      y_q           <= y_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign p_tick      = p_tick_q;
  assign x           = x_q;
  assign y           = y_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: two generators (CLK_DIV=4 and 1) with full horizontal timing and a
// short 7-line frame (3 visible, 1 front, 2 sync, 1 back) so whole frames fit quickly.
module tb_vga_sync_gen;

  logic clk;
  logic reset_n;
  logic mon_en;
  int   n_chk, n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int DIV = (g == 0) ? 4 : 1;
    logic       p_tick, video_on, hsync, vsync, line_start, frame_start;
    logic [9:0] x, y;

    vga_sync_gen #(.CLK_DIV(DIV), .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_dut (
      .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .x(x), .y(y), .video_on(video_on),
      .hsync(hsync), .vsync(vsync), .line_start(line_start), .frame_start(frame_start));

    int cyc, phase, fs_first, fs_period;
    int ptk, hs_cnt, vs_cnt, vo_cnt, ls_cnt, viol;
    int hs_min = 1023, hs_max = 0, vs_min = 1023, vs_max = 0, y_max = 0, x_max = 0;
    int vo_640_0 = -1, vo_0_3 = -1, vo_799_6 = -1, vo_639_2 = -1;
    logic [9:0] px, py;
    logic       pvs;
    logic       in_frame;

    assign in_frame = mon_en && ((phase == 0 && frame_start) || (phase == 1 && !frame_start));

    // Frame statistics, gathered from one frame_start up to the next
    always @(negedge clk) begin
      if (!reset_n) begin
        cyc   <= 0;
        phase <= (phase == 2) ? 2 : 0;
      end else begin
        cyc <= cyc + 1;
        px  <= x;
        py  <= y;
        pvs <= vsync;
        if (mon_en && phase == 0 && frame_start) begin
          phase    <= 1;
          fs_first <= cyc + 1;
        end else if (mon_en && phase == 1 && frame_start) begin
          phase     <= 2;
          fs_period <= cyc + 1 - fs_first;
        end
        if (in_frame) begin
          if (p_tick) begin
            ptk <= ptk + 1;
            if (!hsync)   hs_cnt <= hs_cnt + 1;
            if (!vsync)   vs_cnt <= vs_cnt + 1;
            if (video_on) vo_cnt <= vo_cnt + 1;
            if (x == 640 && y == 0) vo_640_0 <= int'(video_on);
            if (x == 0   && y == 3) vo_0_3   <= int'(video_on);
            if (x == 799 && y == 6) vo_799_6 <= int'(video_on);
            if (x == 639 && y == 2) vo_639_2 <= int'(video_on);
          end
          if (line_start) ls_cnt <= ls_cnt + 1;
          if (!hsync && x < hs_min) hs_min <= x;
          if (!hsync && x > hs_max) hs_max <= x;
          if (!vsync && y < vs_min) vs_min <= y;
          if (!vsync && y > vs_max) vs_max <= y;
          if (y > y_max) y_max <= y;
          if (x > x_max) x_max <= x;
          if ((vsync != pvs && !(x == 0 && px == 799)) ||
              (line_start && x != 0) ||
              (frame_start && (!line_start || y != 0)) ||
              (line_start && y != ((py == 6) ? 10'd0 : py + 10'd1)) ||
              (video_on != (x < 640 && y < 3)) ||
              ((!hsync) != (x >= 656 && x < 752)))
            viol <= viol + 1;
        end
      end
    end
  end

  int ptk_a, ptk_b, step_viol, t;
  logic       pa_prev;
  logic [9:0] xa_prev;

  initial begin
    n_chk = 0; n_fail = 0;
    reset_n = 1'b0; mon_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ptick_a", g_dut[0].p_tick, 0);
    chk("rst_x_a", g_dut[0].x, 0);
    chk("rst_y_a", g_dut[0].y, 0);
    chk("rst_vo_a", g_dut[0].video_on, 0);
    chk("rst_hs_a", g_dut[0].hsync, 1);
    chk("rst_vs_a", g_dut[0].vsync, 1);
    chk("rst_ls_a", g_dut[0].line_start, 0);
    chk("rst_fs_a", g_dut[0].frame_start, 0);
    chk("rst_ptick_b", g_dut[1].p_tick, 0);
    chk("rst_x_b", g_dut[1].x, 0);

    // Divider and x stepping over the first 40 clks
    #2 reset_n = 1'b1;
    ptk_a = 0; ptk_b = 0; step_viol = 0; pa_prev = 1'b0; xa_prev = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (g_dut[0].p_tick) ptk_a++;
      if (g_dut[1].p_tick) ptk_b++;
      if (g_dut[0].x != xa_prev && (!pa_prev || g_dut[0].x != xa_prev + 10'd1)) step_viol++;
      pa_prev = g_dut[0].p_tick;
      xa_prev = g_dut[0].x;
    end
    chk("div4_ptick_count", ptk_a, 10);
    chk("div4_x_after_40", g_dut[0].x, 9);
    chk("div4_x_step", step_viol, 0);
    chk("div1_ptick_count", ptk_b, 40);
    chk("div1_x_after_40", g_dut[1].x, 39);

    mon_en = 1'b1;
    t = 0;
    while (!(g_dut[0].phase == 2 && g_dut[1].phase == 2) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_wait_done", int'(t < 60000), 1);

    chk("a_first_fs_cyc", g_dut[0].fs_first, 22401);
    chk("a_fs_period_clk", g_dut[0].fs_period, 22400);
    chk("a_ptk_frame", g_dut[0].ptk, 5600);
    chk("a_hs_ptk", g_dut[0].hs_cnt, 672);
    chk("a_hs_min", g_dut[0].hs_min, 656);
    chk("a_hs_max", g_dut[0].hs_max, 751);
    chk("a_vs_ptk", g_dut[0].vs_cnt, 1600);
    chk("a_vs_min", g_dut[0].vs_min, 4);
    chk("a_vs_max", g_dut[0].vs_max, 5);
    chk("a_vo_ptk", g_dut[0].vo_cnt, 1920);
    chk("a_ls_cnt", g_dut[0].ls_cnt, 7);
    chk("a_y_max", g_dut[0].y_max, 6);
    chk("a_x_max", g_dut[0].x_max, 799);
    chk("a_vo_640_0", g_dut[0].vo_640_0, 0);
    chk("a_vo_0_3", g_dut[0].vo_0_3, 0);
    chk("a_vo_799_6", g_dut[0].vo_799_6, 0);
    chk("a_vo_639_2", g_dut[0].vo_639_2, 1);
    chk("a_align_viol", g_dut[0].viol, 0);

    chk("b_first_fs_cyc", g_dut[1].fs_first, 5601);
    chk("b_fs_period_clk", g_dut[1].fs_period, 5600);
    chk("b_ptk_frame", g_dut[1].ptk, 5600);
    chk("b_hs_ptk", g_dut[1].hs_cnt, 672);
    chk("b_hs_min", g_dut[1].hs_min, 656);
    chk("b_hs_max", g_dut[1].hs_max, 751);
    chk("b_vs_ptk", g_dut[1].vs_cnt, 1600);
    chk("b_vo_ptk", g_dut[1].vo_cnt, 1920);
    chk("b_ls_cnt", g_dut[1].ls_cnt, 7);
    chk("b_vo_639_2", g_dut[1].vo_639_2, 1);
    chk("b_align_viol", g_dut[1].viol, 0);

    // Asynchronous reset in the middle of a visible line
    t = 0;
    while (!(g_dut[0].x == 300 && g_dut[0].y == 1) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("midline_reached", int'(t < 20000), 1);
    chk("midline_vo_before", g_dut[0].video_on, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_x", g_dut[0].x, 0);
    chk("midrst_y", g_dut[0].y, 0);
    chk("midrst_vo", g_dut[0].video_on, 0);
    chk("midrst_hs", g_dut[0].hsync, 1);
    chk("midrst_vs", g_dut[0].vsync, 1);
    chk("midrst_ptick", g_dut[0].p_tick, 0);
    chk("midrst_ls", g_dut[0].line_start, 0);
    chk("midrst_x_b", g_dut[1].x, 0);
    chk("midrst_ptick_b", g_dut[1].p_tick, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
